// File: rtl/fft_sequencer.sv
// rtl/fft_sequencer.sv - Radix-2 in-place FFT butterfly address sequencer with write-back delay line
module fft_sequencer #(
    parameter int LOG2N  = 4,
    parameter int BF_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             hold,
    output logic             busy,
    output logic             done,
    output logic [2:0]       stage,
    output logic             rd_en,
    output logic [LOG2N-1:0] rd_addr_a,
    output logic [LOG2N-1:0] rd_addr_b,
    output logic [LOG2N-2:0] tw_addr,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addr_a,
    output logic [LOG2N-1:0] wr_addr_b
);
    localparam int JW = LOG2N - 1;
    localparam int NB = 1 << JW;
    localparam int DW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
    localparam logic [JW-1:0] J_LAST = JW'(NB - 1);
    localparam logic [2:0]    S_LAST = 3'(LOG2N - 1);
    localparam logic [DW-1:0] D_LAST = DW'(BF_LAT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t        state;
    logic [JW-1:0] j;
    logic [DW-1:0] drain_cnt;

    logic          do_issue;
    logic [2:0]    nxt_s;
    logic [JW-1:0] nxt_j;
    logic [LOG2N-1:0] nxt_a;
    logic [LOG2N-1:0] nxt_b;
    logic [JW-1:0]    nxt_tw;

    // Butterfly j of stage s pairs points a and a+2^s; the low s bits of j pick the twiddle.
    function automatic logic [LOG2N-1:0] low_mask(input logic [2:0] s);
        return (LOG2N'(1) << s) - LOG2N'(1);
    endfunction

    function automatic logic [LOG2N-1:0] addr_a_of(input logic [2:0] s, input logic [JW-1:0] jj);
        logic [LOG2N-1:0] jx;
        jx = LOG2N'(jj);
        return ((jx >> s) << (s + 3'd1)) | (jx & low_mask(s));
    endfunction

    function automatic logic [JW-1:0] tw_of(input logic [2:0] s, input logic [JW-1:0] jj);
        logic [LOG2N-1:0] jx;
        jx = LOG2N'(jj);
        return JW'((jx & low_mask(s)) << (S_LAST - s));
    endfunction

    // Next butterfly to present on the read port, and whether it is presented at this edge.
    always_comb begin
        do_issue = 1'b0;
        nxt_s    = stage;
        nxt_j    = j + JW'(1);
        case (state)
            IDLE: begin
                do_issue = start;
                nxt_s    = 3'd0;
                nxt_j    = '0;
            end
            ISSUE: begin
                do_issue = !hold && (j != J_LAST);
            end
            DRAIN: begin
                do_issue = (drain_cnt == D_LAST) && (stage != S_LAST);
                nxt_s    = stage + 3'd1;
                nxt_j    = '0;
            end
            default: begin
                do_issue = 1'b0;
            end
        endcase
        nxt_a  = addr_a_of(nxt_s, nxt_j);
        nxt_b  = nxt_a + (LOG2N'(1) << nxt_s);
        nxt_tw = tw_of(nxt_s, nxt_j);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            stage     <= 3'd0;
            j         <= '0;
            drain_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            tw_addr   <= '0;
        end else begin
            done  <= 1'b0;
            rd_en <= do_issue;
            if (do_issue) begin
                rd_addr_a <= nxt_a;
                rd_addr_b <= nxt_b;
                tw_addr   <= nxt_tw;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ISSUE;
                        busy  <= 1'b1;
                        stage <= 3'd0;
                        j     <= '0;
                    end
                end
                ISSUE: begin
                    if (j == J_LAST) begin
                        state     <= DRAIN;
                        j         <= '0;
                        drain_cnt <= '0;
                    end else if (!hold) begin
                        j <= j + JW'(1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt == D_LAST) begin
                        drain_cnt <= '0;
                        if (stage == S_LAST) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ISSUE;
                            stage <= stage + 3'd1;
                            j     <= '0;
                        end
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Write-back mirrors the read port BF_LAT cycles later; cleared on reset so an aborted pass writes nothing.
    logic [BF_LAT-1:0] wr_en_sr;
    logic [LOG2N-1:0]  wa_sr [BF_LAT];
    logic [LOG2N-1:0]  wb_sr [BF_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_sr <= '0;
            for (int i = 0; i < BF_LAT; i++) begin
                wa_sr[i] <= '0;
                wb_sr[i] <= '0;
            end
        end else begin
            wr_en_sr[0] <= rd_en;
            wa_sr[0]    <= rd_addr_a;
            wb_sr[0]    <= rd_addr_b;
            for (int i = 1; i < BF_LAT; i++) begin
                wr_en_sr[i] <= wr_en_sr[i-1];
                wa_sr[i]    <= wa_sr[i-1];
                wb_sr[i]    <= wb_sr[i-1];
            end
        end
    end

    assign wr_en     = wr_en_sr[BF_LAT-1];
    assign wr_addr_a = wa_sr[BF_LAT-1];
    assign wr_addr_b = wb_sr[BF_LAT-1];

endmodule
